// File: rtl/bfly_pkg.sv
// rtl/bfly_pkg.sv - shared types and helpers for the R2SDF butterfly stage (honours BFLY_R2SDF_SAT_EN)
package bfly_pkg;

  // Half-frame phase: PH_FILL loads the delay line, PH_BFLY combines head and input.
  typedef enum logic {PH_FILL, PH_BFLY} phase_t;

  // Beat counter width covering 0..2*delay-1.
  function automatic int CNT_W(input int delay);
    return $clog2(delay) + 1;
  endfunction

  // Resize a signed value to `width` bits, returned sign-extended to 32 bits.
  // With BFLY_R2SDF_SAT_EN out-of-range values clamp; otherwise they wrap.
  function automatic logic signed [31:0] sat_resize(input logic signed [31:0] value,
                                                    input int width);
`ifdef BFLY_R2SDF_SAT_EN
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (value > max_v) return max_v;
    if (value < min_v) return min_v;
    return value;
`else
    int sh;
    sh = 32 - width;
    return (value <<< sh) >>> sh;
`endif
  endfunction

endpackage

// File: rtl/sdf_delay_buf.sv
// rtl/sdf_delay_buf.sv - per-lane circular delay line, one read and one write per enabled beat
module sdf_delay_buf #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 20
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    ptr_d;

  // Head is the entry written DEPTH beats ago; it is overwritten by this beat's write.
  assign rdata_o = mem_q[ptr_q];

  // Single pointer serves both read and write, wrapping after DEPTH entries.
  always_comb begin
    ptr_d = ptr_q;
    if (we_i) ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  // Storage has no reset; contents are never observed before being written.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/bfly_r2sdf_stage.sv
// rtl/bfly_r2sdf_stage.sv - radix-2 SDF butterfly stage, NUM lanes; BFLY_R2SDF_SAT_EN selects saturation
module bfly_r2sdf_stage
  import bfly_pkg::*;
#(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 10,
  parameter int NUM       = 16,
  parameter int DELAY     = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_in,
  input  logic                     sof_in,
  input  logic                     scale_en,
  input  logic [NUM*IN_WIDTH-1:0]  din_re,
  input  logic [NUM*IN_WIDTH-1:0]  din_im,
  output logic [NUM*OUT_WIDTH-1:0] dout_re,
  output logic [NUM*OUT_WIDTH-1:0] dout_im,
  output logic                     valid_out,
  output logic                     sof_out
);

  localparam int CW = CNT_W(DELAY);
  localparam int AW = IN_WIDTH + 1;
  localparam int BW = 2 * AW;

  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
  logic          diff_q, diff_d, diff_eff;
  logic          scale_q, scale_d;
  logic          valid_q, sof_q;
  logic          start, resync, emit;
  phase_t        phase;

  // Beat sequencing: sof restarts the frame; a mid-frame sof also drops pending differences.
  always_comb begin
    start    = valid_in && sof_in;
    resync   = start && (cnt_q != '0);
    cnt_eff  = start ? '0 : cnt_q;
    phase    = cnt_eff[CW-1] ? PH_BFLY : PH_FILL;
    diff_eff = diff_q && !resync;
    emit     = valid_in && ((phase == PH_BFLY) || diff_eff);
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    scale_d  = scale_q;
    if (valid_in) begin
      cnt_d  = cnt_eff + CW'(1);
      diff_d = diff_eff || (&cnt_eff);
      if (sof_in) scale_d = scale_en;
    end
  end

  // Control state and output handshake registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      diff_q  <= 1'b0;
      scale_q <= 1'b0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      scale_q <= scale_d;
      valid_q <= emit;
      sof_q   <= valid_in && (cnt_eff == CW'(DELAY));
    end
  end

  assign valid_out = valid_q;
  assign sof_out   = sof_q;

  for (genvar l = 0; l < NUM; l++) begin : g_lane
    logic signed [AW-1:0]    x_re, x_im, h_re, h_im;
    logic signed [AW-1:0]    s_re, s_im, d_re, d_im, r_re, r_im;
    logic signed [31:0]      w_re, w_im;
    logic [BW-1:0]           rd, wd;
    logic [OUT_WIDTH-1:0]    o_re_d, o_im_d, o_re_q, o_im_q;

    sdf_delay_buf #(.DEPTH(DELAY), .WIDTH(BW)) u_buf (
      .clk_i   (clk),
      .rstn_i  (rstn),
      .we_i    (valid_in),
      .wdata_i (wd),
      .rdata_o (rd)
    );

    // Butterfly: fill stores the input, bfly emits the scaled sum and stores the scaled difference.
    always_comb begin
      x_re = {din_re[l*IN_WIDTH+IN_WIDTH-1], din_re[l*IN_WIDTH +: IN_WIDTH]};
      x_im = {din_im[l*IN_WIDTH+IN_WIDTH-1], din_im[l*IN_WIDTH +: IN_WIDTH]};
      h_re = rd[BW-1:AW];
      h_im = rd[AW-1:0];
      s_re = h_re + x_re;
      s_im = h_im + x_im;
      d_re = h_re - x_re;
      d_im = h_im - x_im;
      if (scale_q) begin
        s_re = s_re >>> 1;
        s_im = s_im >>> 1;
        d_re = d_re >>> 1;
        d_im = d_im >>> 1;
      end
      if (phase == PH_FILL) begin
        wd   = {x_re, x_im};
        r_re = h_re;
        r_im = h_im;
      end else begin
        wd   = {d_re, d_im};
        r_re = s_re;
        r_im = s_im;
      end
      w_re   = r_re;
      w_im   = r_im;
      o_re_d = OUT_WIDTH'(sat_resize(w_re, OUT_WIDTH));
      o_im_d = OUT_WIDTH'(sat_resize(w_im, OUT_WIDTH));
    end

    // Output data holds its value on beats that emit nothing.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        o_re_q <= '0;
        o_im_q <= '0;
      end else if (emit) begin
        o_re_q <= o_re_d;
        o_im_q <= o_im_d;
      end
    end

    assign dout_re[l*OUT_WIDTH +: OUT_WIDTH] = o_re_q;
    assign dout_im[l*OUT_WIDTH +: OUT_WIDTH] = o_im_q;
  end

endmodule
